// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for iterative_alu and seq_muldiv.
//   - 4-bit opcode encodings (compatible with the single-cycle ALU, plus
//     logic/compare/shift/mul/div extensions)
//   - FSM state enum (IDLE, BUSY)
//   - is_multicycle(op): true for ops executed by the iterative datapath
package alu_pkg;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_NOR  = 4'b0001;
  localparam logic [3:0] OP_OR   = 4'b0010;
  localparam logic [3:0] OP_ADD  = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0100;
  localparam logic [3:0] OP_LUI  = 4'b0101;
  localparam logic [3:0] OP_SLT  = 4'b0110;
  localparam logic [3:0] OP_SLL  = 4'b0111;
  localparam logic [3:0] OP_SRL  = 4'b1000;
  localparam logic [3:0] OP_MULU = 4'b1001;
  localparam logic [3:0] OP_DIVU = 4'b1010;
  localparam logic [3:0] OP_REMU = 4'b1011;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  function automatic logic is_multicycle(input logic [3:0] op);
    return (op == OP_MULU) || (op == OP_DIVU) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/seq_muldiv.sv
// seq_muldiv: iterative unsigned multiply / divide, one step per clock.
//   MULU: LSB-first shift-add, low WIDTH bits of the product.
//   DIVU/REMU: restoring division, one quotient bit per step.
//   A start (ignored while busy) latches operands; exactly WIDTH steps
//   follow. done_o is a combinational pulse during the final step and
//   result_o carries the value that step produces, so the caller registers
//   it on the same edge that completes the operation.
// Ports:
//   clk_i, rst_n_i   clock, async active-low reset
//   start_i          begin a new operation (caller only pulses it when idle)
//   op_i             opcode (MULU / DIVU / REMU)
//   a_i, b_i         operands
//   done_o           high during the last iteration cycle
//   result_o         result, valid while done_o=1
module seq_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  localparam int                CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(WIDTH - 1);

  logic             r_busy;
  logic [CNT_W-1:0] r_cnt;
  logic             r_mul;   // 1: multiply, 0: divide
  logic             r_rem;   // divide: return remainder instead of quotient
  // Shared operand registers:
  //   multiply: r_acc = partial product, r_x = multiplicand (<<1 per step),
  //             r_y = multiplier (>>1 per step)
  //   divide:   r_acc = partial remainder, r_x = dividend shifting out
  //             MSB-first while quotient bits shift in, r_y = divisor
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] r_y;

  logic [WIDTH-1:0] w_acc_mul;
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH:0]   w_diff;
  logic             w_fits;
  logic [WIDTH-1:0] w_rem_nx;
  logic [WIDTH-1:0] w_quo_nx;

  always_comb begin
    w_acc_mul = r_y[0] ? (r_acc + r_x) : r_acc;
    w_rem_sh  = {r_acc, r_x[WIDTH-1]};
    // Bit WIDTH of the difference is set exactly when the divisor does not
    // fit. A zero divisor always fits, which naturally yields an all-ones
    // quotient and a remainder equal to the dividend.
    w_diff    = w_rem_sh - {1'b0, r_y};
    w_fits    = ~w_diff[WIDTH];
    w_rem_nx  = w_fits ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
    w_quo_nx  = {r_x[WIDTH-2:0], w_fits};
  end

  assign done_o   = r_busy && (r_cnt == LAST);
  assign result_o = r_mul ? w_acc_mul : (r_rem ? w_rem_nx : w_quo_nx);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
      r_mul  <= 1'b0;
      r_rem  <= 1'b0;
      r_acc  <= '0;
      r_x    <= '0;
      r_y    <= '0;
    end else if (!r_busy) begin
      if (start_i) begin
        r_busy <= 1'b1;
        r_cnt  <= '0;
        r_mul  <= (op_i == OP_MULU);
        r_rem  <= (op_i == OP_REMU);
        r_acc  <= '0;
        r_x    <= a_i;
        r_y    <= b_i;
      end
    end else begin
      r_cnt <= r_cnt + 1'b1;
      if (r_mul) begin
        r_acc <= w_acc_mul;
        r_x   <= {r_x[WIDTH-2:0], 1'b0};
        r_y   <= {1'b0, r_y[WIDTH-1:1]};
      end else begin
        r_acc <= w_rem_nx;
        r_x   <= w_quo_nx;
      end
      if (r_cnt == LAST) begin
        r_busy <= 1'b0;
        r_cnt  <= '0;
      end
    end
  end

endmodule

// File: rtl/iterative_alu.sv
// iterative_alu: registered EX-stage ALU with start/valid/ready handshake.
//   Single-cycle ops (AND NOR OR ADD SUB LUI SLT SLL SRL) produce valid_o
//   the cycle after the accepting edge; back-to-back starts are allowed.
//   MULU/DIVU/REMU (only when ALU_MULDIV_EN is defined) run WIDTH steps in
//   seq_muldiv with ready_o low; valid_o and ready_o rise together.
//   Without ALU_MULDIV_EN those opcodes are undefined (result 0, one cycle)
//   and ready_o is tied high. Undefined opcodes return 0.
// Ports:
//   clk_i, rst_n_i       clock, async active-low reset
//   start_i              request, accepted when ready_o=1
//   alu_operation_i      opcode, a_i / b_i operands (sampled on accept)
//   ready_o              idle and able to accept
//   valid_o              one-cycle pulse, alu_data_o / zero_o valid
//   alu_data_o, zero_o   registered result and (result==0)
module iterative_alu
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic [3:0]       alu_operation_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             ready_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] alu_data_o,
  output logic             zero_o
);

  logic [WIDTH-1:0]   w_sc_res;
  logic [SHAMT_W-1:0] w_shamt;

  assign w_shamt = b_i[SHAMT_W-1:0];

  always_comb begin
    w_sc_res = '0;
    case (alu_operation_i)
      OP_AND: w_sc_res = a_i & b_i;
      OP_NOR: w_sc_res = ~(a_i | b_i);
      OP_OR:  w_sc_res = a_i | b_i;
      OP_ADD: w_sc_res = a_i + b_i;
      OP_SUB: w_sc_res = a_i - b_i;
      OP_LUI: w_sc_res = {b_i[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      OP_SLT: w_sc_res = {{(WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      OP_SLL: w_sc_res = a_i << w_shamt;
      OP_SRL: w_sc_res = a_i >> w_shamt;
      default: w_sc_res = '0;
    endcase
  end

  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic             r_zero;

  assign valid_o    = r_valid;
  assign alu_data_o = r_data;
  assign zero_o     = r_zero;

`ifdef ALU_MULDIV_EN
  state_t           r_state;
  logic             r_ready;
  logic             w_mc_start;
  logic             w_done;
  logic [WIDTH-1:0] w_mc_res;

  assign w_mc_start = start_i && (r_state == IDLE) && is_multicycle(alu_operation_i);
  assign ready_o    = r_ready;

  seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .start_i  (w_mc_start),
    .op_i     (alu_operation_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .done_o   (w_done),
    .result_o (w_mc_res)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= IDLE;
      r_ready <= 1'b1;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_zero  <= 1'b1;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start_i) begin
            if (is_multicycle(alu_operation_i)) begin
              r_state <= BUSY;
              r_ready <= 1'b0;
            end else begin
              r_valid <= 1'b1;
              r_data  <= w_sc_res;
              r_zero  <= (w_sc_res == '0);
            end
          end
        end
        BUSY: begin
          // start_i is deliberately not looked at here: no queuing.
          if (w_done) begin
            r_state <= IDLE;
            r_ready <= 1'b1;
            r_valid <= 1'b1;
            r_data  <= w_mc_res;
            r_zero  <= (w_mc_res == '0);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
`else
  assign ready_o = 1'b1;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_zero  <= 1'b1;
    end else begin
      r_valid <= start_i;
      if (start_i) begin
        r_data <= w_sc_res;
        r_zero <= (w_sc_res == '0);
      end
    end
  end
`endif

endmodule

// File: tb/tb_iterative_alu.sv
// tb_iterative_alu: directed self-checking bench for iterative_alu (WIDTH=32).
// Inputs are driven and outputs sampled on the falling edge; the DUT acts on
// the rising edge in between. Multi-cycle checks depend on ALU_MULDIV_EN.
module tb_iterative_alu;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        ready;
  logic        valid;
  logic [31:0] data;
  logic        zero;

  int passed = 0;
  int total  = 0;
  int failed = 0;

  iterative_alu #(.WIDTH(32)) dut (
    .clk_i           (clk),
    .rst_n_i         (rst_n),
    .start_i         (start),
    .alu_operation_i (op),
    .a_i             (a),
    .b_i             (b),
    .ready_o         (ready),
    .valid_o         (valid),
    .alu_data_o      (data),
    .zero_o          (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One single-cycle op: drive, let the DUT accept, check the next cycle.
  task automatic sc(input string tag, input logic [3:0] o, input logic [31:0] x,
                    input logic [31:0] y, input logic [31:0] exp);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    check({tag, " valid"}, 32'(valid), 32'd1);
    check({tag, " data"},  data, exp);
    check({tag, " zero"},  32'(zero), 32'(exp == 32'd0));
    check({tag, " ready"}, 32'(ready), 32'd1);
  endtask

  // One multi-cycle op: measure latency, ready-low cycles and valid pulses.
  // Operands are scrambled while busy and, optionally, a stray start is
  // pulsed in cycle 5.
  task automatic mc(input string tag, input logic [3:0] o, input logic [31:0] x,
                    input logic [31:0] y, input logic [31:0] exp, input bit stray);
    int lat, nlow, nval;
    logic [31:0] got;
    logic gz;
    lat = 0; nlow = 0; nval = 0; got = '0; gz = 1'b0;
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; a = 32'hDEAD_BEEF; b = 32'h0000_0003;
    for (int k = 1; k <= 40; k++) begin
      if (!ready) nlow++;
      if (valid) begin
        nval++;
        if (lat == 0) begin lat = k; got = data; gz = zero; end
      end
      start = stray && (k == 5);
      if (start) op = 4'b0011;
      @(negedge clk);
    end
    start = 1'b0;
    check({tag, " latency"},   32'(lat),  32'd33);
    check({tag, " ready_low"}, 32'(nlow), 32'd32);
    check({tag, " pulses"},    32'(nval), 32'd1);
    check({tag, " data"},      got, exp);
    check({tag, " zero"},      32'(gz), 32'(exp == 32'd0));
  endtask

  initial begin
    int nval;
    rst_n = 1'b0; start = 1'b0; op = 4'b0000; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("rst ready", 32'(ready), 32'd1);
    check("rst valid", 32'(valid), 32'd0);
    check("rst data",  data,       32'd0);
    check("rst zero",  32'(zero),  32'd1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle valid", 32'(valid), 32'd0);
    check("idle ready", 32'(ready), 32'd1);

    // Back-to-back ADD / LUI / SLT
    start = 1'b1; op = 4'b0011; a = 32'hFFFF_FFFF; b = 32'd1;
    @(negedge clk);
    check("add valid", 32'(valid), 32'd1);
    check("add data",  data,       32'd0);
    check("add zero",  32'(zero),  32'd1);
    op = 4'b0101; a = 32'h5555_5555; b = 32'hABCD_1234;
    @(negedge clk);
    check("lui valid", 32'(valid), 32'd1);
    check("lui data",  data,       32'h1234_0000);
    check("lui zero",  32'(zero),  32'd0);
    op = 4'b0110; a = 32'hFFFF_FFFF; b = 32'd1;
    @(negedge clk);
    start = 1'b0;
    check("slt valid", 32'(valid), 32'd1);
    check("slt data",  data,       32'd1);
    @(negedge clk);
    check("hold valid", 32'(valid), 32'd0);
    check("hold data",  data,       32'd1);

    sc("and",  4'b0000, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200);
    sc("nor",  4'b0001, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF);
    sc("or",   4'b0010, 32'hA000_0001, 32'h0500_0010, 32'hA500_0011);
    sc("sub",  4'b0100, 32'd3,         32'd5,         32'hFFFF_FFFE);
    sc("slt2", 4'b0110, 32'd1,         32'hFFFF_FFFF, 32'd0);
    sc("sll",  4'b0111, 32'd1,         32'd31,        32'h8000_0000);
    sc("srl",  4'b1000, 32'h8000_0000, 32'h0000_0024, 32'h0800_0000);
    sc("undef",4'b1100, 32'h1234_5678, 32'h1111_1111, 32'd0);

`ifdef ALU_MULDIV_EN
    mc("mulu", 4'b1001, 32'd7,   32'd6, 32'd42,         1'b1);
    mc("divu", 4'b1010, 32'd100, 32'd7, 32'd14,         1'b0);
    mc("remu", 4'b1011, 32'd100, 32'd7, 32'd2,          1'b0);
    mc("div0", 4'b1010, 32'd5,   32'd0, 32'hFFFF_FFFF,  1'b0);
    mc("rem0", 4'b1011, 32'd5,   32'd0, 32'd5,          1'b0);
    mc("mulb", 4'b1001, 32'h0001_0001, 32'hFFFF_FFFF, 32'hFFFE_FFFF, 1'b0);
`else
    sc("mulu_off", 4'b1001, 32'd7,   32'd6, 32'd0);
    sc("divu_off", 4'b1010, 32'd100, 32'd7, 32'd0);
    sc("remu_off", 4'b1011, 32'd5,   32'd0, 32'd0);
`endif

    // Make alu_data_o nonzero, then abort a MULU with reset in cycle 10.
    sc("pre", 4'b0010, 32'd9, 32'd0, 32'd9);
    start = 1'b1; op = 4'b1001; a = 32'd7; b = 32'd6;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort ready", 32'(ready), 32'd1);
    check("abort valid", 32'(valid), 32'd0);
    check("abort data",  data,       32'd0);
    check("abort zero",  32'(zero),  32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    nval = 0;
    for (int k = 0; k < 40; k++) begin
      if (valid) nval++;
      @(negedge clk);
    end
    check("abort no_valid", 32'(nval), 32'd0);
    sc("add_after", 4'b0011, 32'd2, 32'd3, 32'd5);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
